// File: rtl/camera_reg_sequencer_if.sv
// Bus between the camera register sequencer, its register table and the I2C register controller.
interface camera_reg_sequencer_if;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic        wrreg_req;
    logic        rdreg_req;
    logic [15:0] addr;
    logic        addr_mode;
    logic [7:0]  wrdata;
    logic [7:0]  device_id;
    logic        RW_Done;
    logic        ack;
    logic [7:0]  rddata;

    modport master (
        output lut_index, wrreg_req, rdreg_req, addr, addr_mode, wrdata, device_id,
        input  lut_data, RW_Done, ack, rddata
    );
    modport slave (
        input  lut_index, wrreg_req, rdreg_req, addr, addr_mode, wrdata, device_id,
        output lut_data, RW_Done, ack, rddata
    );
endinterface

// File: rtl/camera_reg_sequencer.sv
// Power-up sensor register loader: walks the table, writes each entry over I2C with retry, honours delay entries.
// Define CAM_INIT_VERIFY_EN to read back every acked write and compare before advancing.
module camera_reg_sequencer #(
    parameter int unsigned TABLE_SIZE   = 168,
    parameter logic [7:0]  DEVICE_ID    = 8'h42,
    parameter logic        ADDR_MODE    = 1'b0,
    parameter int unsigned PWR_DLY_CYC  = 1_000_000,
    parameter int unsigned DLY_UNIT_CYC = 50_000,
    parameter int unsigned TIMEOUT_CYC  = 100_000,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   start,
    camera_reg_sequencer_if.master bus,
    output logic                   busy,
    output logic                   init_done,
    output logic                   init_err,
    output logic [7:0]             err_index
);
    if (TABLE_SIZE > 255) begin : g_size_chk
        $error("TABLE_SIZE must fit the 8-bit index without wrapping");
    end

    typedef enum logic [3:0] {
        IDLE, PWR_WAIT, FETCH, LATCH, ISSUE, DELAY, WAIT_DONE, CHECK,
`ifdef CAM_INIT_VERIFY_EN
        RD_ISSUE, RD_WAIT, COMPARE,
`endif
        DONE, ERROR
    } state_t;

    state_t      state, nxt;
    logic [7:0]  index, retry;
    logic [31:0] cnt, dly_len;
    logic [15:0] addr_r;
    logic [7:0]  wrdata_r;
    logic        ack_r;
    logic        advance, fail, last, retry_last, tmo, is_delay, start_go;

    assign last       = (32'(index) + 32'd1) == TABLE_SIZE;
    assign retry_last = (32'(retry) + 32'd1) >= RETRY_MAX;
    assign tmo        = (cnt + 32'd1) >= TIMEOUT_CYC;
    assign is_delay   = bus.lut_data[23:8] == 16'hFFFF;
    assign start_go   = start && (state inside {IDLE, DONE, ERROR});

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt     = state;
        advance = 1'b0;
        fail    = 1'b0;
        case (state)
            IDLE, DONE, ERROR: if (start) nxt = PWR_WAIT;
            PWR_WAIT:  if ((cnt + 32'd1) >= PWR_DLY_CYC) nxt = (TABLE_SIZE == 0) ? DONE : FETCH;
            FETCH:     nxt = LATCH;
            LATCH:     nxt = is_delay ? DELAY : ISSUE;
            DELAY:     if ((cnt + 32'd1) >= dly_len) advance = 1'b1;
            ISSUE:     nxt = WAIT_DONE;
            WAIT_DONE: if (bus.RW_Done || tmo) nxt = CHECK;
`ifdef CAM_INIT_VERIFY_EN
            CHECK:     if (ack_r) fail = 1'b1; else nxt = RD_ISSUE;
            RD_ISSUE:  nxt = RD_WAIT;
            RD_WAIT:   if (bus.RW_Done || tmo) nxt = COMPARE;
            COMPARE:   if (ack_r) fail = 1'b1; else advance = 1'b1;
`else
            CHECK:     if (ack_r) fail = 1'b1; else advance = 1'b1;
`endif
            default:   nxt = IDLE;
        endcase
        if (advance) nxt = last ? DONE : FETCH;
        if (fail)    nxt = retry_last ? ERROR : ISSUE;
    end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            index     <= '0;
            retry     <= '0;
            cnt       <= '0;
            dly_len   <= '0;
            addr_r    <= '0;
            wrdata_r  <= '0;
            ack_r     <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
        end else begin
            // one shared counter, restarted on every state change
            cnt <= (nxt != state) ? '0 : cnt + 32'd1;
            if (start_go) begin
                index     <= '0;
                retry     <= '0;
                init_done <= 1'b0;
                init_err  <= 1'b0;
                err_index <= '0;
            end
            if (state == LATCH) begin
                if (is_delay) dly_len <= 32'(bus.lut_data[7:0]) * DLY_UNIT_CYC;
                else begin
                    addr_r   <= ADDR_MODE ? bus.lut_data[23:8] : {8'h00, bus.lut_data[15:8]};
                    wrdata_r <= bus.lut_data[7:0];
                end
            end
            // a timeout is folded in as a NACK
            if (state == WAIT_DONE && nxt == CHECK) ack_r <= bus.RW_Done ? bus.ack : 1'b1;
`ifdef CAM_INIT_VERIFY_EN
            if (state == RD_WAIT && nxt == COMPARE)
                ack_r <= bus.RW_Done ? (bus.ack | (bus.rddata != wrdata_r)) : 1'b1;
`endif
            if (advance) begin
                index <= index + 8'd1;
                retry <= '0;
            end
            if (fail) retry <= retry + 8'd1;
            if (nxt == DONE && state != DONE) init_done <= 1'b1;
            if (fail && retry_last) begin
                init_err  <= 1'b1;
                err_index <= index;
            end
        end

    assign busy          = !(state inside {IDLE, DONE, ERROR});
    assign bus.lut_index = index;
    assign bus.wrreg_req = (state == ISSUE);
    assign bus.addr      = addr_r;
    assign bus.wrdata    = wrdata_r;
    assign bus.addr_mode = ADDR_MODE;
    assign bus.device_id = DEVICE_ID;
`ifdef CAM_INIT_VERIFY_EN
    assign bus.rdreg_req = (state == RD_ISSUE);
`else
    assign bus.rdreg_req = 1'b0;
    logic unused_rddata;
    assign unused_rddata = ^bus.rddata;
`endif
endmodule

// File: tb/tb_camera_reg_sequencer.sv
// Randomized bench for camera_reg_sequencer: table + I2C slave responder, checked against a per-entry attempt model.
module tb_camera_reg_sequencer;
    localparam int TS = 6, PWR = 20, DLY = 10, TO = 100, RM = 3, LIMIT = 5000;

    logic Clk = 1'b0, Rst_n = 1'b0, start = 1'b0, start0 = 1'b0;
    logic busy, init_done, init_err, busy0, init_done0, init_err0;
    logic [7:0] err_index, err_index0;

    camera_reg_sequencer_if bus ();
    camera_reg_sequencer_if bus0 ();

    camera_reg_sequencer #(.TABLE_SIZE(TS), .DEVICE_ID(8'h42), .ADDR_MODE(1'b0), .PWR_DLY_CYC(PWR),
        .DLY_UNIT_CYC(DLY), .TIMEOUT_CYC(TO), .RETRY_MAX(RM)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .bus(bus),
        .busy(busy), .init_done(init_done), .init_err(init_err), .err_index(err_index));

    camera_reg_sequencer #(.TABLE_SIZE(0), .PWR_DLY_CYC(PWR), .DLY_UNIT_CYC(DLY),
        .TIMEOUT_CYC(TO), .RETRY_MAX(RM)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .start(start0), .bus(bus0),
        .busy(busy0), .init_done(init_done0), .init_err(init_err0), .err_index(err_index0));

    always #5 Clk = ~Clk;

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [23:0] tbl [TS];
    int fail_cfg [TS], fail_left [TS], rd_bad [TS], rd_left [TS], first_gap [TS], retry_gap [TS];
    bit hold [TS];
    int rsp_cnt = -1, done_cyc = 0, prev_wr = 0, prev_e = -1, rd_cnt = 0, lut_prev = 0, wr0_cnt = 0;
    logic        rsp_ack = 1'b0;
    logic [7:0]  rsp_rd = 8'h0, last_wr = 8'h0;
    logic [23:0] cap = '0;
    logic [23:0] obs_q [$];

    // table ROM with one cycle of read latency
    always @(negedge Clk) begin : lut
        bus.lut_data = (lut_prev < TS) ? tbl[lut_prev] : 24'h0;
        lut_prev = int'(bus.lut_index);
    end

    always @(negedge Clk) if (bus0.wrreg_req) wr0_cnt++;

    // I2C controller model: random latency, scripted NACKs / withheld completions
    always @(negedge Clk) begin : rsp
        int e;
        bus.RW_Done = 1'b0;
        bus.ack     = 1'b0;
        if (!Rst_n) rsp_cnt = -1;
        else if (rsp_cnt == 0) begin
            bus.RW_Done = 1'b1;
            bus.ack     = rsp_ack;
            bus.rddata  = rsp_rd;
            rsp_cnt     = -1;
            done_cyc    = cyc;
            chk("bus_stable", {8'h0, bus.addr, bus.wrdata}, {8'h0, cap});
        end else if (rsp_cnt > 0) rsp_cnt--;
        e = int'(bus.lut_index);
        if (Rst_n && bus.wrreg_req && e < TS) begin
            cap = {bus.addr, bus.wrdata};
            obs_q.push_back(cap);
            last_wr = bus.wrdata;
            if (first_gap[e] < 0) first_gap[e] = cyc - done_cyc;
            else if (e == prev_e) retry_gap[e] = cyc - prev_wr;
            prev_wr = cyc;
            prev_e  = e;
            if (fail_left[e] > 0) begin
                fail_left[e]--;
                rsp_ack = 1'b1;
                if (!hold[e]) rsp_cnt = int'($urandom_range(0, 4));
            end else begin
                rsp_ack = 1'b0;
                rsp_cnt = int'($urandom_range(0, 4));
            end
        end
        if (Rst_n && bus.rdreg_req && e < TS) begin
            rd_cnt++;
            cap     = {bus.addr, last_wr};
            rsp_ack = 1'b0;
            rsp_cnt = int'($urandom_range(0, 4));
            if (rd_left[e] > 0) begin
                rd_left[e]--;
                rsp_rd = last_wr ^ 8'h01;
            end else rsp_rd = last_wr;
        end
    end

    task automatic clr_cfg();
        for (int e = 0; e < TS; e++) begin
            fail_cfg[e] = 0;
            rd_bad[e]   = 0;
            hold[e]     = 1'b0;
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_lut_index"}, bus.lut_index, 0);
        chk({tag, "_wrreg"}, bus.wrreg_req, 0);
        chk({tag, "_rdreg"}, bus.rdreg_req, 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_wrdata"}, bus.wrdata, 0);
        chk({tag, "_flags"}, {busy, init_done, init_err}, 0);
        chk({tag, "_err_index"}, err_index, 0);
        chk({tag, "_addr_mode"}, bus.addr_mode, 0);
        chk({tag, "_device_id"}, bus.device_id, 8'h42);
    endtask

    // Model: each real entry gets min(fails+1, RM) identical writes; fails >= RM stops the load there.
    task automatic run_load(input string tag);
        logic [23:0] exp_q [$];
        bit exp_err = 1'b0;
        int exp_eidx = 0, exp_rd = 0, n, f;
        for (int e = 0; e < TS; e++) begin
            fail_left[e] = fail_cfg[e];
            rd_left[e]   = rd_bad[e];
            first_gap[e] = -1;
            retry_gap[e] = -1;
        end
        for (int e = 0; e < TS && !exp_err; e++) begin
            if (tbl[e][23:8] == 16'hFFFF) continue;
            f = fail_cfg[e] + rd_bad[e];
            n = (f >= RM) ? RM : f + 1;
            for (int k = 0; k < n; k++) exp_q.push_back({8'h00, tbl[e][15:0]});
            exp_rd += (n > fail_cfg[e]) ? n - fail_cfg[e] : 0;
            if (f >= RM) begin
                exp_err  = 1'b1;
                exp_eidx = e;
            end
        end
        obs_q.delete();
        rd_cnt = 0;
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        n = 0;
        while (busy && n < LIMIT) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_finish"}, 32'(n < LIMIT), 1);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_wr"}, {8'h0, obs_q[i]}, {8'h0, exp_q[i]});
        chk({tag, "_done"}, init_done, !exp_err);
        chk({tag, "_err"}, init_err, exp_err);
        chk({tag, "_err_index"}, err_index, exp_eidx);
        chk({tag, "_busy"}, busy, 0);
`ifdef CAM_INIT_VERIFY_EN
        chk({tag, "_nrd"}, rd_cnt, exp_rd);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

    initial begin
        int r, n;
        logic [15:0] a16;
        bus.RW_Done = 1'b0; bus.ack = 1'b0; bus.rddata = 8'h0; bus.lut_data = 24'h0;
        bus0.RW_Done = 1'b0; bus0.ack = 1'b0; bus0.rddata = 8'h0; bus0.lut_data = 24'h0;
        clr_cfg();
        for (int e = 0; e < TS; e++) begin
            tbl[e] = 24'h0;
            first_gap[e] = -1;
            retry_gap[e] = -1;
            fail_left[e] = 0;
            rd_left[e] = 0;
        end
        repeat (3) @(negedge Clk);
        reset_chk("rst");
        Rst_n = 1'b1;

        // empty table completes straight after the power-up wait
        @(negedge Clk) start0 = 1'b1;
        @(negedge Clk) start0 = 1'b0;
        repeat (PWR + 3) @(negedge Clk);
        chk("ts0_done", {busy0, init_done0, init_err0}, 3'b010);
        chk("ts0_nowr", wr0_cnt, 0);

        tbl[0] = 24'h001280; tbl[1] = 24'h001101; tbl[2] = 24'h003A04;
        tbl[3] = 24'h002055; tbl[4] = 24'h002166; tbl[5] = 24'h002277;
        run_load("t1");

        tbl[1] = 24'hFFFF05;
        run_load("t2");
        chk("t2_gap", first_gap[2], 5 * DLY + 6);
        tbl[1] = 24'h001101;

        fail_cfg[1] = 2;
        run_load("t3");

        clr_cfg();
        fail_cfg[2] = 3;
        run_load("t4");
        clr_cfg();
        run_load("t4_rerun");

        fail_cfg[1] = 1; hold[1] = 1'b1;
        run_load("t5");
        chk("t5_gap", retry_gap[1], TO + 2);

        // reset while the first write is waiting for a completion that never comes
        clr_cfg();
        fail_left[0] = 5; hold[0] = 1'b1;
        obs_q.delete();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        n = 0;
        while (obs_q.size() == 0 && n < LIMIT) begin
            @(negedge Clk);
            n++;
        end
        chk("t5_req_seen", 32'(n < LIMIT), 1);
        repeat (10) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        reset_chk("t5_midrst");
        @(negedge Clk) Rst_n = 1'b1;
        clr_cfg();
        fail_left[0] = 0;

`ifdef CAM_INIT_VERIFY_EN
        rd_bad[0] = 1;
        run_load("t6");
        clr_cfg();
`endif

        for (int it = 0; it < 12; it++) begin
            for (int e = 0; e < TS; e++) begin
                r = int'($urandom_range(0, 4));
                if (r == 0) tbl[e] = {16'hFFFF, 8'($urandom_range(0, 3))};
                else begin
                    a16 = 16'($urandom);
                    if (a16 == 16'hFFFF) a16 = 16'h0000;
                    tbl[e] = {a16, 8'($urandom)};
                end
                r = int'($urandom_range(0, 19));
                fail_cfg[e] = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? 2 : 3;
                hold[e]     = ($urandom_range(0, 3) == 0);
                rd_bad[e]   = 0;
            end
            run_load("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
